// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader:
// FSM state encoding, header width and packer byte-index width.
package imem_loader_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_HDR0,
    S_HDR1,
    S_DATA,
    S_WRITE,
    S_CKSUM,
    S_HOLD,
    S_RUN,
    S_ERR
  } state_t;

  localparam int HDR_W = 16;
  localparam int IDX_W = 2;

endpackage

// File: rtl/imem_word_packer.sv
// Big-endian byte-to-word packer for the boot loader.
// Shifts bytes into a 32-bit word, tracks the byte index and flags the
// cycle after the fourth byte (used directly as the IM write strobe).
// With IMEM_LOAD_CHECKSUM_EN defined it also keeps a running XOR of all
// shifted bytes.
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic             i_shift,
  input  logic [7:0]       i_byte,
  output logic [31:0]      o_word,
  output logic             o_last,
  output logic             o_word_done
`ifdef IMEM_LOAD_CHECKSUM_EN
  ,
  output logic [7:0]       o_xor
`endif
);

  logic [31:0]      r_word;
  logic [IDX_W-1:0] r_idx;
  logic             r_word_done;

  assign o_word      = r_word;
  assign o_last      = (r_idx == {IDX_W{1'b1}});
  assign o_word_done = r_word_done;

  // Shift register, byte index and word-complete pulse
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_word      <= '0;
      r_idx       <= '0;
      r_word_done <= 1'b0;
    end else if (i_clear) begin
      r_word      <= '0;
      r_idx       <= '0;
      r_word_done <= 1'b0;
    end else begin
      r_word_done <= i_shift && o_last;
      if (i_shift) begin
        r_word <= {r_word[23:0], i_byte};
        r_idx  <= r_idx + IDX_W'(1);
      end
    end
  end

`ifdef IMEM_LOAD_CHECKSUM_EN
  logic [7:0] r_xor;
  assign o_xor = r_xor;

  // Running XOR of every data byte in the session
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)        r_xor <= '0;
    else if (i_clear) r_xor <= '0;
    else if (i_shift) r_xor <= r_xor ^ i_byte;
  end
`endif

endmodule

// File: rtl/imem_boot_loader.sv
// Instruction-memory boot loader.
// Receives "N (16b, MSB first) + 4*N data bytes" and writes N big-endian
// words to IM addresses 0..N-1, holding the CPU in reset until HOLD_CYC
// cycles after the last write.
// Optional: IMEM_LOAD_CHECKSUM_EN adds a trailing XOR byte checked in CKSUM.
//
// state | meaning
// IDLE  | after reset, CPU held, waiting for load_start
// HDR0  | accept word-count MSB
// HDR1  | accept word-count LSB, validate N
// DATA  | accept data bytes into the packer
// WRITE | one-cycle IM write of the assembled word
// CKSUM | accept and compare trailing XOR byte (optional)
// HOLD  | keep CPU in reset for HOLD_CYC cycles
// RUN   | CPU released, load done
// ERR   | session aborted, CPU held until next load_start
module imem_boot_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int HOLD_CYC = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load_start,
  input  logic              i_byte_valid,
  input  logic [7:0]        i_byte_data,
  output logic              o_byte_ready,
  output logic              o_im_we,
  output logic [ADDR_W-1:0] o_im_addr,
  output logic [31:0]       o_im_wdata,
  output logic              o_cpu_rst,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [15:0]       o_word_cnt
);

  localparam int HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_CYC - 1);

  state_t             r_state;
  logic               r_byte_ready;
  logic [ADDR_W-1:0]  r_im_addr;
  logic               r_cpu_rst;
  logic               r_busy;
  logic               r_done;
  logic               r_err;
  logic [HDR_W-1:0]   r_word_cnt;
  logic [HDR_W-1:0]   r_n;
  logic [HOLD_W-1:0]  r_hold_cnt;

  logic               w_accept;
  logic [HDR_W-1:0]   w_hdr;
  logic               w_hdr_over;
  logic [HDR_W-1:0]   w_cnt_inc;
  logic               w_last;
  logic               w_word_done;
  logic [31:0]        w_word;
`ifdef IMEM_LOAD_CHECKSUM_EN
  logic [7:0]         w_xor;
`endif

  assign w_accept   = i_byte_valid && r_byte_ready;
  assign w_hdr      = {r_n[15:8], i_byte_data};
  assign w_hdr_over = ({16'd0, w_hdr} > (32'd1 << ADDR_W));
  assign w_cnt_inc  = r_word_cnt + HDR_W'(1);

  imem_word_packer u_packer (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_clear     (w_accept && (r_state == S_HDR1)),
    .i_shift     (w_accept && (r_state == S_DATA)),
    .i_byte      (i_byte_data),
    .o_word      (w_word),
    .o_last      (w_last),
    .o_word_done (w_word_done)
`ifdef IMEM_LOAD_CHECKSUM_EN
    ,
    .o_xor       (w_xor)
`endif
  );

  assign o_byte_ready = r_byte_ready;
  assign o_im_we      = w_word_done;
  assign o_im_addr    = r_im_addr;
  assign o_im_wdata   = w_word;
  assign o_cpu_rst    = r_cpu_rst;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_err        = r_err;
  assign o_word_cnt   = r_word_cnt;

  // Session FSM; outputs are set on the transition into each state
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_byte_ready <= 1'b0;
      r_im_addr    <= '0;
      r_cpu_rst    <= 1'b1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_word_cnt   <= '0;
      r_n          <= '0;
      r_hold_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_RUN, S_ERR: begin
          if (i_load_start) begin
            r_state      <= S_HDR0;
            r_byte_ready <= 1'b1;
            r_cpu_rst    <= 1'b1;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
          end
        end
        S_HDR0: begin
          if (w_accept) begin
            r_n[15:8] <= i_byte_data;
            r_state   <= S_HDR1;
          end
        end
        S_HDR1: begin
          if (w_accept) begin
            r_n[7:0]   <= i_byte_data;
            r_im_addr  <= '0;
            r_word_cnt <= '0;
            if (w_hdr == '0) begin
`ifdef IMEM_LOAD_CHECKSUM_EN
              r_state      <= S_CKSUM;
`else
              r_state      <= S_HOLD;
              r_byte_ready <= 1'b0;
              r_hold_cnt   <= HOLD_INIT;
`endif
            end else if (w_hdr_over) begin
              r_state      <= S_ERR;
              r_byte_ready <= 1'b0;
              r_busy       <= 1'b0;
              r_err        <= 1'b1;
            end else begin
              r_state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (w_accept && w_last) begin
            r_state      <= S_WRITE;
            r_byte_ready <= 1'b0;
          end
        end
        S_WRITE: begin
          r_im_addr  <= r_im_addr + ADDR_W'(1);
          r_word_cnt <= w_cnt_inc;
          if (w_cnt_inc == r_n) begin
`ifdef IMEM_LOAD_CHECKSUM_EN
            r_state      <= S_CKSUM;
            r_byte_ready <= 1'b1;
`else
            r_state    <= S_HOLD;
            r_hold_cnt <= HOLD_INIT;
`endif
          end else begin
            r_state      <= S_DATA;
            r_byte_ready <= 1'b1;
          end
        end
`ifdef IMEM_LOAD_CHECKSUM_EN
        S_CKSUM: begin
          if (w_accept) begin
            r_byte_ready <= 1'b0;
            if (i_byte_data == w_xor) begin
              r_state    <= S_HOLD;
              r_hold_cnt <= HOLD_INIT;
            end else begin
              r_state <= S_ERR;
              r_busy  <= 1'b0;
              r_err   <= 1'b1;
            end
          end
        end
`endif
        S_HOLD: begin
          if (r_hold_cnt == '0) begin
            r_state   <= S_RUN;
            r_cpu_rst <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
          end else begin
            r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_byte_ready <= 1'b0;
          r_cpu_rst    <= 1'b1;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed testbench for imem_boot_loader: reset, basic load, backpressure,
// oversize header, ignored load_start, mid-load reset, N=0, full capacity,
// and checksum handling when IMEM_LOAD_CHECKSUM_EN is defined.
module tb_imem_boot_loader;

  localparam int ADDR_W   = 10;
  localparam int HOLD_CYC = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              load_start = 1'b0;
  logic              byte_valid = 1'b0;
  logic [7:0]        byte_data = 8'h00;
  logic              byte_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;
  logic              cpu_rst;
  logic              busy;
  logic              done;
  logic              err;
  logic [15:0]       word_cnt;

  imem_boot_loader #(.ADDR_W(ADDR_W), .HOLD_CYC(HOLD_CYC)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_load_start (load_start),
    .i_byte_valid (byte_valid),
    .i_byte_data  (byte_data),
    .o_byte_ready (byte_ready),
    .o_im_we      (im_we),
    .o_im_addr    (im_addr),
    .o_im_wdata   (im_wdata),
    .o_cpu_rst    (cpu_rst),
    .o_busy       (busy),
    .o_done       (done),
    .o_err        (err),
    .o_word_cnt   (word_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];
  int          log_cyc[$];
  bit          ready_in_write = 1'b0;
  int          fall_cyc = -1;
  bit          prev_cpu_rst = 1'b1;
  logic [7:0]  tb_xor = 8'h00;

  always @(posedge clk) cyc++;

  // Record IM writes and the cpu_rst falling edge, sampled mid-cycle
  always @(negedge clk) begin
    if (im_we) begin
      log_addr.push_back(32'(im_addr));
      log_data.push_back(im_wdata);
      log_cyc.push_back(cyc);
      if (byte_ready) ready_in_write = 1'b1;
    end
    if (prev_cpu_rst && !cpu_rst) fall_cyc = cyc;
    prev_cpu_rst = cpu_rst;
  end

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
    log_cyc.delete();
    ready_in_write = 1'b0;
    fall_cyc = -1;
    tb_xor = 8'h00;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    bit ok = 1'b0;
    if (gap) begin
      byte_valid = 1'b0;
      @(posedge clk); #1;
    end
    byte_valid = 1'b1;
    byte_data  = b;
    for (int t = 0; t < 40 && !ok; t++) begin
      @(negedge clk);
      if (byte_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    byte_valid = 1'b0;
    n_checks++;
    if (!ok) begin
      n_err++;
      $display("FAIL byte_accept: byte %h not accepted, want accepted within 40 cycles", b);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    for (int i = 3; i >= 0; i--) begin
      tb_xor = tb_xor ^ w[i*8 +: 8];
      send_byte(w[i*8 +: 8], gap);
    end
  endtask

  task automatic send_cksum(input bit gap);
`ifdef IMEM_LOAD_CHECKSUM_EN
    send_byte(tb_xor, gap);
`else
    if (gap) begin
      @(posedge clk); #1;
    end
`endif
  endtask

  task automatic wait_done(input int budget);
    bit seen = 1'b0;
    for (int t = 0; t < budget && !seen; t++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    @(posedge clk); #1;
    n_checks++;
    if (!seen) begin
      n_err++;
      $display("FAIL done_timeout: done=%b after %0d cycles, want 1", done, budget);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #100;
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (cpu_rst !== 1'b1) begin n_err++; $display("FAIL rst_cpu_rst: got %b want 1", cpu_rst); end
    n_checks++; if (byte_ready !== 1'b0) begin n_err++; $display("FAIL rst_byte_ready: got %b want 0", byte_ready); end
    n_checks++; if (im_addr !== '0) begin n_err++; $display("FAIL rst_im_addr: got %h want 0", im_addr); end
    n_checks++; if (im_wdata !== 32'h0) begin n_err++; $display("FAIL rst_im_wdata: got %h want 0", im_wdata); end
    n_checks++; if ({busy, done, err} !== 3'b000) begin n_err++; $display("FAIL rst_flags: busy/done/err got %b want 000", {busy, done, err}); end
    n_checks++; if (word_cnt !== 16'd0) begin n_err++; $display("FAIL rst_word_cnt: got %0d want 0", word_cnt); end
    repeat (20) @(negedge clk);
    n_checks++; if (cpu_rst !== 1'b1) begin n_err++; $display("FAIL idle_cpu_rst: got %b want 1", cpu_rst); end
    n_checks++; if (byte_ready !== 1'b0) begin n_err++; $display("FAIL idle_byte_ready: got %b want 0", byte_ready); end
    n_checks++; if (log_addr.size() != 0) begin n_err++; $display("FAIL idle_im_we: got %0d writes want 0", log_addr.size()); end
  endtask

  task automatic test_basic(input bit gap);
    logic [31:0] a0, a1, d0, d1;
    clear_log();
    pulse_start();
    send_byte(8'h00, gap);
    send_byte(8'h02, gap);
    send_word(32'h20080005, gap);
    send_word(32'hAC080000, gap);
    send_cksum(gap);
    wait_done(40);
    a0 = (log_addr.size() > 0) ? log_addr[0] : 'x;
    d0 = (log_data.size() > 0) ? log_data[0] : 'x;
    a1 = (log_addr.size() > 1) ? log_addr[1] : 'x;
    d1 = (log_data.size() > 1) ? log_data[1] : 'x;
    n_checks++; if (log_addr.size() != 2) begin n_err++; $display("FAIL basic_we_count(gap=%0d): got %0d want 2", gap, log_addr.size()); end
    n_checks++; if (a0 !== 32'd0 || d0 !== 32'h20080005) begin n_err++; $display("FAIL basic_w0(gap=%0d): got addr %h data %h want 0 20080005", gap, a0, d0); end
    n_checks++; if (a1 !== 32'd1 || d1 !== 32'hAC080000) begin n_err++; $display("FAIL basic_w1(gap=%0d): got addr %h data %h want 1 ac080000", gap, a1, d1); end
    n_checks++; if (word_cnt !== 16'd2) begin n_err++; $display("FAIL basic_word_cnt(gap=%0d): got %0d want 2", gap, word_cnt); end
    n_checks++; if ({done, cpu_rst, busy, err} !== 4'b1000) begin n_err++; $display("FAIL basic_run(gap=%0d): done/cpu_rst/busy/err got %b want 1000", gap, {done, cpu_rst, busy, err}); end
    n_checks++; if (ready_in_write) begin n_err++; $display("FAIL basic_ready_in_write(gap=%0d): got byte_ready=1 during WRITE want 0", gap); end
`ifndef IMEM_LOAD_CHECKSUM_EN
    n_checks++;
    if (log_cyc.size() != 2 || fall_cyc - log_cyc[log_cyc.size()-1] != HOLD_CYC + 1) begin
      n_err++;
      $display("FAIL basic_hold_timing(gap=%0d): got fall at cycle %0d, %0d writes, want %0d cycles after last write",
               gap, fall_cyc, log_cyc.size(), HOLD_CYC + 1);
    end
`endif
  endtask

  task automatic test_oversize();
    logic [31:0] a0, d0;
    clear_log();
    pulse_start();
    send_byte(8'h04, 1'b0);
    send_byte(8'h01, 1'b0);
    repeat (3) @(negedge clk);
    n_checks++; if ({err, cpu_rst, busy, byte_ready, done} !== 5'b11000) begin n_err++; $display("FAIL oversize_err: err/cpu_rst/busy/ready/done got %b want 11000", {err, cpu_rst, busy, byte_ready, done}); end
    n_checks++; if (log_addr.size() != 0) begin n_err++; $display("FAIL oversize_no_write: got %0d writes want 0", log_addr.size()); end
    pulse_start();
    n_checks++; if ({err, busy, byte_ready, cpu_rst} !== 4'b0111) begin n_err++; $display("FAIL oversize_restart: err/busy/ready/cpu_rst got %b want 0111", {err, busy, byte_ready, cpu_rst}); end
    // load_start mid-DATA must not restart the session
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    tb_xor = 8'hDE ^ 8'hAD;
    send_byte(8'hDE, 1'b0);
    send_byte(8'hAD, 1'b0);
    pulse_start();
    tb_xor = tb_xor ^ 8'hBE ^ 8'hEF;
    send_byte(8'hBE, 1'b0);
    send_byte(8'hEF, 1'b0);
    send_cksum(1'b0);
    wait_done(40);
    a0 = (log_addr.size() > 0) ? log_addr[0] : 'x;
    d0 = (log_data.size() > 0) ? log_data[0] : 'x;
    n_checks++; if (log_addr.size() != 1 || a0 !== 32'd0 || d0 !== 32'hDEADBEEF) begin n_err++; $display("FAIL busy_start_ignored: got %0d writes addr %h data %h want 1 0 deadbeef", log_addr.size(), a0, d0); end
  endtask

  task automatic test_mid_reset();
    logic [31:0] a0, d0;
    clear_log();
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    send_word(32'h11223344, 1'b0);
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b0);
    n_checks++; if (im_addr !== 10'd1 || word_cnt !== 16'd1) begin n_err++; $display("FAIL midrst_pre: got addr %h cnt %0d want 1 1", im_addr, word_cnt); end
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if ({cpu_rst, byte_ready, im_we, busy, done, err} !== 6'b100000) begin n_err++; $display("FAIL midrst_flags: cpu_rst/ready/we/busy/done/err got %b want 100000", {cpu_rst, byte_ready, im_we, busy, done, err}); end
    n_checks++; if (im_addr !== '0 || im_wdata !== 32'h0 || word_cnt !== 16'd0) begin n_err++; $display("FAIL midrst_regs: got addr %h data %h cnt %0d want 0 0 0", im_addr, im_wdata, word_cnt); end
    @(posedge clk); #1;
    rst = 1'b0;
    clear_log();
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    send_word(32'hCAFEF00D, 1'b0);
    send_cksum(1'b0);
    wait_done(40);
    a0 = (log_addr.size() > 0) ? log_addr[0] : 'x;
    d0 = (log_data.size() > 0) ? log_data[0] : 'x;
    n_checks++; if (log_addr.size() != 1 || a0 !== 32'd0 || d0 !== 32'hCAFEF00D) begin n_err++; $display("FAIL midrst_reload: got %0d writes addr %h data %h want 1 0 cafef00d", log_addr.size(), a0, d0); end
    n_checks++; if (word_cnt !== 16'd1) begin n_err++; $display("FAIL midrst_word_cnt: got %0d want 1", word_cnt); end
  endtask

  task automatic test_zero();
    clear_log();
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_cksum(1'b0);
    wait_done(40);
    n_checks++; if (log_addr.size() != 0 || word_cnt !== 16'd0) begin n_err++; $display("FAIL zero_len: got %0d writes cnt %0d want 0 0", log_addr.size(), word_cnt); end
    n_checks++; if ({done, cpu_rst} !== 2'b10) begin n_err++; $display("FAIL zero_run: done/cpu_rst got %b want 10", {done, cpu_rst}); end
  endtask

  task automatic test_full();
    logic [31:0] al, dl;
    clear_log();
    pulse_start();
    send_byte(8'h04, 1'b0);
    send_byte(8'h00, 1'b0);
    for (int i = 0; i < 1024; i++) send_word(32'hA5000000 | 32'(i), 1'b0);
    send_cksum(1'b0);
    wait_done(40);
    al = (log_addr.size() == 1024) ? log_addr[1023] : 'x;
    dl = (log_data.size() == 1024) ? log_data[1023] : 'x;
    n_checks++; if (log_addr.size() != 1024) begin n_err++; $display("FAIL full_we_count: got %0d want 1024", log_addr.size()); end
    n_checks++; if (al !== 32'd1023 || dl !== 32'hA50003FF) begin n_err++; $display("FAIL full_last: got addr %h data %h want 3ff a50003ff", al, dl); end
    n_checks++; if (word_cnt !== 16'd1024 || im_addr !== '0) begin n_err++; $display("FAIL full_cnt_wrap: got cnt %0d addr %h want 1024 0", word_cnt, im_addr); end
    n_checks++; if ({done, cpu_rst, err} !== 3'b100) begin n_err++; $display("FAIL full_run: done/cpu_rst/err got %b want 100", {done, cpu_rst, err}); end
  endtask

`ifdef IMEM_LOAD_CHECKSUM_EN
  task automatic test_cksum_bad();
    clear_log();
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    send_word(32'h20080005, 1'b0);
    send_word(32'hAC080000, 1'b0);
    send_byte(~tb_xor, 1'b0);
    repeat (10) @(negedge clk);
    n_checks++; if ({err, cpu_rst, done} !== 3'b110) begin n_err++; $display("FAIL cksum_bad: err/cpu_rst/done got %b want 110", {err, cpu_rst, done}); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic(1'b0);
    test_basic(1'b1);
    test_oversize();
    test_mid_reset();
    test_zero();
    test_full();
`ifdef IMEM_LOAD_CHECKSUM_EN
    test_cksum_bad();
`endif
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
